// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of 2**CH_BITS independent clock dividers with shadow-loaded divisors.
// Optional macro CLK_DIV_BANK_SYNC_EN adds the iSync phase-align input.
module clk_div_bank #(
    parameter int unsigned CH_BITS     = 2,
    parameter int unsigned CNT_BITS    = 8,
    parameter int unsigned DEFAULT_DIV = 8
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iWrEn,
    input  logic [CH_BITS-1:0]      ivWrChan,
    input  logic [CNT_BITS-1:0]     ivWrDiv,
    input  logic [(2**CH_BITS)-1:0] ivChanEn,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic                    iSync,
`endif
    output logic [(2**CH_BITS)-1:0] ovClkDiv,
    output logic [(2**CH_BITS)-1:0] ovTick,
    output logic [(2**CH_BITS)-1:0] ovPending
);
    localparam int unsigned CHANNELS = 2**CH_BITS;
    localparam logic [CNT_BITS-1:0] DEF_DIV =
        (DEFAULT_DIV < 32'd2) ? CNT_BITS'(2) : CNT_BITS'(DEFAULT_DIV);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    // Divisors below 2 cannot form a period, so they are stored as 2.
    function automatic logic [CNT_BITS-1:0] clamp_div(input logic [CNT_BITS-1:0] v);
        return (v < CNT_BITS'(2)) ? CNT_BITS'(2) : v;
    endfunction

    logic sync_c;
`ifdef CLK_DIV_BANK_SYNC_EN
    assign sync_c = iSync;
`else
    assign sync_c = 1'b0;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_e              state_q, state_d;
        logic [CNT_BITS-1:0] cnt_q, cnt_d;
        logic [CNT_BITS-1:0] div_q, div_d;
        logic [CNT_BITS-1:0] shd_q, shd_d;
        logic                pend_q, pend_d;
        logic                tick_q, tick_d;
        logic                clk_q, clk_d;
        logic                en_c, wrap_c, restart_c, wr_hit_c;
        logic [CNT_BITS:0]   half_c;

        assign en_c      = ivChanEn[g];
        assign wrap_c    = (state_q == ST_RUN) && (cnt_q == div_q - CNT_BITS'(1));
        assign restart_c = en_c && ((state_q == ST_IDLE) || wrap_c || sync_c);
        assign wr_hit_c  = iWrEn && (ivWrChan == CH_BITS'(g));
        // High phase length ceil(D/2), computed on the divisor in force next cycle.
        assign half_c    = ({1'b0, div_d} + (CNT_BITS+1)'(1)) >> 1;

        // Next state: apply the shadow at period start or while idle, then land any write.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            shd_d   = shd_q;
            pend_d  = pend_q;
            if (pend_q && ((state_q == ST_IDLE) || restart_c)) begin
                div_d  = shd_q;
                pend_d = 1'b0;
            end
            if (wr_hit_c) begin
                shd_d  = clamp_div(ivWrDiv);
                pend_d = 1'b1;
            end
            if (!en_c) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (restart_c) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_BITS'(1);
            end
            tick_d = en_c && (cnt_d == '0);
            clk_d  = en_c && ({1'b0, cnt_d} < half_c);
        end

        always_ff @(posedge iClk or negedge iRst) begin
            if (!iRst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                div_q   <= DEF_DIV;
                shd_q   <= DEF_DIV;
                pend_q  <= 1'b0;
                tick_q  <= 1'b0;
                clk_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                shd_q   <= shd_d;
                pend_q  <= pend_d;
                tick_q  <= tick_d;
                clk_q   <= clk_d;
            end
        end

        assign ovTick[g]    = tick_q;
        assign ovClkDiv[g]  = clk_q;
        assign ovPending[g] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and randomized checks of clk_div_bank against a period-level model.
module tb_clk_div_bank;
    logic       iClk;
    logic       iRst;
    logic       iWrEn;
    logic [1:0] ivWrChan;
    logic [7:0] ivWrDiv;
    logic [3:0] ivChanEn;
    logic       iSync;
    logic [3:0] ovClkDiv, ovTick, ovPending;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel position in period, divisor, shadow, pending, running.
    int m_c[4], m_d[4], m_s[4];
    bit m_p[4], m_run[4];

    clk_div_bank #(.CH_BITS(2), .CNT_BITS(8), .DEFAULT_DIV(8)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iWrEn    (iWrEn),
        .ivWrChan (ivWrChan),
        .ivWrDiv  (ivWrDiv),
        .ivChanEn (ivChanEn),
`ifdef CLK_DIV_BANK_SYNC_EN
        .iSync    (iSync),
`endif
        .ovClkDiv (ovClkDiv),
        .ovTick   (ovTick),
        .ovPending(ovPending)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_c[ch] = 0; m_d[ch] = 8; m_s[ch] = 8; m_p[ch] = 1'b0; m_run[ch] = 1'b0;
        end
    endtask

    // One clock edge: a channel that was idle, or that starts a new period, adopts its pending divisor.
    task automatic model_step();
        for (int ch = 0; ch < 4; ch++) begin
            bit was_run, start;
            was_run = m_run[ch];
            start   = 1'b0;
            if (!ivChanEn[ch]) begin
                m_run[ch] = 1'b0;
                m_c[ch]   = 0;
            end else begin
                if (!was_run || iSync) m_c[ch] = 0;
                else                   m_c[ch] = (m_c[ch] + 1) % m_d[ch];
                m_run[ch] = 1'b1;
                start     = (m_c[ch] == 0);
            end
            if (m_p[ch] && (!was_run || start)) begin
                m_d[ch] = m_s[ch];
                m_p[ch] = 1'b0;
            end
            if (iWrEn && (int'(ivWrChan) == ch)) begin
                m_s[ch] = (ivWrDiv < 2) ? 2 : int'(ivWrDiv);
                m_p[ch] = 1'b1;
            end
        end
    endtask

    task automatic cmp_model();
        logic [3:0] et, ec, ep;
        for (int ch = 0; ch < 4; ch++) begin
            et[ch] = m_run[ch] && (m_c[ch] == 0);
            ec[ch] = m_run[ch] && (m_c[ch] < (m_d[ch] + 1) / 2);
            ep[ch] = m_p[ch];
        end
        chk("tick", 32'(ovTick), 32'(et));
        chk("clkdiv", 32'(ovClkDiv), 32'(ec));
        chk("pending", 32'(ovPending), 32'(ep));
    endtask

    task automatic step();
        @(posedge iClk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] div);
        iWrEn = 1'b1; ivWrChan = ch; ivWrDiv = div;
        step();
        iWrEn = 1'b0;
    endtask

    // Measure one full period of a channel starting at its next tick.
    task automatic period(input int ch, input int exp_g, input int exp_hi, input string tag);
        int n, g, hi;
        n = 0;
        while (!ovTick[ch] && n < 300) begin step(); n++; end
        chk({tag, "_tick_seen"}, 32'(n < 300), 32'd1);
        g = 0; hi = 0;
        do begin
            hi += int'(ovClkDiv[ch]);
            step();
            g++;
        end while (!ovTick[ch] && g < 300);
        chk({tag, "_gap"}, 32'(g), 32'(exp_g));
        chk({tag, "_high"}, 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        int n, g, pc;
        iRst = 1'b0; iWrEn = 1'b0; ivWrChan = '0; ivWrDiv = '0; ivChanEn = '0; iSync = 1'b0;
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_tick", 32'(ovTick), 32'd0);
        chk("rst_clkdiv", 32'(ovClkDiv), 32'd0);
        chk("rst_pending", 32'(ovPending), 32'd0);
        iRst = 1'b1;

        // Default divisor 8 on ch0; ch3 also runs for the wrap-edge write.
        ivChanEn = 4'b1001;
        step();
        chk("en_rise_tick0", 32'(ovTick[0]), 32'd1);
        period(0, 8, 4, "ch0_div8");

        // ch1 reprogrammed to 5 while running at 8.
        ivChanEn = 4'b1011;
        repeat (3) step();
        write(2'd1, 8'd5);
        chk("ch1_pending", 32'(ovPending[1]), 32'd1);
        n = 0;
        while (ovPending[1] && n < 300) begin step(); n++; end
        chk("ch1_applied_tick", 32'(ovTick[1]), 32'd1);
        period(1, 5, 3, "ch1_div5");

        // ch2 written 0 then 1 while idle: both clamp to 2.
        write(2'd2, 8'd0);
        write(2'd2, 8'd1);
        step();
        ivChanEn[2] = 1'b1;
        step();
        period(2, 2, 1, "ch2_div2");

        // Write to ch3 on its wrap edge: old divisor runs one more period.
        n = 0;
        while (!(m_run[3] && m_c[3] == m_d[3] - 1) && n < 300) begin step(); n++; end
        write(2'd3, 8'd3);
        chk("ch3_wrap_tick", 32'(ovTick[3]), 32'd1);
        g = 0; pc = 0;
        do begin
            pc += int'(ovPending[3]);
            step();
            g++;
        end while (!ovTick[3] && g < 300);
        chk("ch3_old_gap", 32'(g), 32'd8);
        chk("ch3_pending_len", 32'(pc), 32'd8);
        period(3, 3, 2, "ch3_div3");

        // Drop ch0 enable at C=3, then re-enable.
        n = 0;
        while (m_c[0] != 3 && n < 300) begin step(); n++; end
        ivChanEn[0] = 1'b0;
        step();
        chk("drop_clkdiv0", 32'(ovClkDiv[0]), 32'd0);
        chk("drop_tick0", 32'(ovTick[0]), 32'd0);
        ivChanEn[0] = 1'b1;
        step();
        chk("reen_tick0", 32'(ovTick[0]), 32'd1);
        chk("reen_clkdiv0", 32'(ovClkDiv[0]), 32'd1);

        // Randomized enables and writes, checked every cycle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ivChanEn = ivChanEn ^ 4'($urandom);
            iWrEn    = ($urandom_range(0, 3) == 0);
            ivWrChan = 2'($urandom);
            ivWrDiv  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            step();
        end
        iWrEn = 1'b0;

        // Reset mid-period with a write still pending on ch0.
        ivChanEn = 4'hF;
        write(2'd0, 8'd9);
        #2;
        iRst = 1'b0;
        #1;
        model_reset();
        chk("midrst_tick", 32'(ovTick), 32'd0);
        chk("midrst_clkdiv", 32'(ovClkDiv), 32'd0);
        chk("midrst_pending", 32'(ovPending), 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        step();
        chk("postrst_ticks", 32'(ovTick), 32'hF);
        period(0, 8, 4, "postrst_ch0");

`ifdef CLK_DIV_BANK_SYNC_EN
        // Divisors 4/6/10 at random phases, aligned by one iSync pulse.
        ivChanEn = 4'b0000;
        step();
        write(2'd0, 8'd4);
        write(2'd1, 8'd6);
        write(2'd2, 8'd10);
        step();
        ivChanEn = 4'b0001;
        repeat ($urandom_range(1, 5)) step();
        ivChanEn = 4'b0011;
        repeat ($urandom_range(1, 5)) step();
        ivChanEn = 4'b0111;
        repeat ($urandom_range(1, 20)) step();
        iSync = 1'b1;
        step();
        iSync = 1'b0;
        chk("sync_ticks", 32'(ovTick[2:0]), 32'h7);
        n = 0;
        do begin step(); n++; end while (ovTick[2:0] != 3'b111 && n < 200);
        chk("sync_coincidence_gap", 32'(n), 32'd60);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel clock divider bank with runtime-programmable divisors. It is the parametrised successor to the fixed per-instance divider: a single block holds 2**CH_BITS independent channels. Each channel has its own enable, a shadow-loaded divisor and both square-wave and single-cycle tick outputs. It sits beside the system clock root and feeds slow strobes and derived clocks to peripherals.

## Interface
- CH_BITS, 2, channel-select width; CHANNELS = 2**CH_BITS
- CNT_BITS, 8, divisor/counter width
- DEFAULT_DIV, 8, divisor loaded into every channel at reset (values <2 clamp to 2)

- iClk  in  1  system clock, rising edge
- iRst  in  1  asynchronous, active-low reset
- iWrEn  in  1  divisor write strobe, one write per cycle
- ivWrChan  in  CH_BITS  target channel of write
- ivWrDiv  in  CNT_BITS  divisor value written
- ivChanEn  in  CHANNELS  per-channel run enable
- ovClkDiv  out  CHANNELS  divided square wave per channel
- ovTick  out  CHANNELS  one-cycle pulse at each period start
- ovPending  out  CHANNELS  shadow divisor written but not yet active
- iSync  in  1  phase-align strobe (only with CLK_DIV_BANK_SYNC_EN)

## Operation
- Per channel: active divisor D (CNT_BITS), shadow divisor S, pending flag P, counter C in 0..D-1.
- Written divisor values 0 or 1 are stored as 2. D range is 2..2**CNT_BITS-1.
- Channel states:
  - IDLE (enable low): C held at 0; ovClkDiv=0; ovTick=0.
  - RUN (enable high): C increments and wraps from D-1 to 0.
- RUN outputs: ovTick=1 while C==0. ovClkDiv=1 while C < ceil(D/2), giving ceil(D/2) cycles high and floor(D/2) cycles low.
- Write (iWrEn=1): S[ivWrChan] <= clamped ivWrDiv; P <= 1. A later write before apply overwrites S (last write wins).
- Apply: D <= S, P <= 0.
  - In RUN, apply occurs on the wrap edge (C==D-1 → 0).
  - In IDLE, apply occurs on the next edge.
- Write and wrap on the same edge: the wrap applies the old S. The new write lands in S with P=1 and takes effect at the following wrap.
- Enable dropped mid-period: the channel enters IDLE on the next edge and outputs go 0 immediately (no period completion). Any pending S is applied while idle.
- Channels are fully independent. Writes to one channel never disturb another channel's counter.

## Timing
- Reset (iRst=0, asynchronous): C=0, D=S=clamp(DEFAULT_DIV), P=0, all outputs 0. Deassertion is taken synchronously at the next iClk edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Enable rise: ivChanEn sampled high at edge k gives ovTick=1 and ovClkDiv=1 in the cycle after edge k (C=0). After that, ovTick repeats every D cycles.
- Write latency: ovPending rises the cycle after the iWrEn edge. It falls the cycle after the apply edge.
- Period boundary: the first cycle using the new D is the cycle with C==0 following the wrap.
- Reset mid-period: outputs drop asynchronously. The shadowed write is discarded.

## Configuration
- CLK_DIV_BANK_SYNC_EN defined:
  - Adds port iSync.
  - iSync=1 sampled at an edge forces every RUN channel to C=0 on that edge and applies any pending S.
  - All enabled channels then present ovTick=1 in the same cycle.
  - iSync has priority over a simultaneous wrap or write. A simultaneous write lands in S, leaves P=1, and is applied at the next wrap.
- Not defined: no iSync port and no phase alignment. Channels free-run from their own enable edges.

## Test plan
- Reset DEFAULT_DIV=8, enable ch0: ovTick[0] pulses every 8 cycles; ovClkDiv[0] is 4 high / 4 low.
- Write ch1 divisor 5 while running at 8: ovPending[1]=1 until the wrap. Afterwards ovClkDiv[1] is 3 high / 2 low, with a 5-cycle tick spacing.
- Write divisor 0 and then 1 to ch2: both are stored as 2, so ovClkDiv[2] toggles every cycle and ovTick[2] is high every other cycle.
- Write to ch3 on its exact wrap edge: the old divisor runs one more full period, then the new divisor takes effect. ovPending[3] stays high for that period.
- Drop ivChanEn[0] mid-period at C=3: outputs are 0 next cycle. On re-enable, the tick appears one cycle after the enable edge. Assert iRst mid-period: all outputs clear immediately.
- With CLK_DIV_BANK_SYNC_EN, channels at divisors 4/6/10 with random phases: a single iSync pulse aligns all ovTick pulses to the same cycle, and the next coincidence occurs 60 cycles later.
